aes128_bus_ctrl: RTL and testbench
==================================

// Module: aes128_bus_ctrl
// PURPOSE
//  Bus-side initiator for the AES-128 engine. Exposes 32-bit memory-mapped key, data, result,
//  control and status registers to the TinyQV peripheral bus. Launches the engine via its
//  start/op/key/data handshake, captures the 128-bit result on completion and raises DONE/irq.
//  Sits between the peripheral wrapper and aes128_fsm; both share clk_i/rst_n_i.
// PARAMETERS
//  ADDR_W        6  byte-address width; map decoded on addr_i[5:2], addr_i[1:0] ignored
//  IRQ_EN_RST    0  reset value of CTRL.IRQ_EN
// PORTS
//  clk_i          in   1    clock, all state on posedge
//  rst_n_i        in   1    synchronous active-low reset
//  addr_i         in   6    byte address (ADDR_W)
//  wdata_i        in   32   write data
//  wr_i           in   1    word write strobe, one cycle per access
//  rd_i           in   1    read strobe, one cycle per access
//  rdata_o        out  32   read data, registered
//  rd_valid_o     out  1    1-cycle pulse, rdata_o valid (cycle after rd_i)
//  irq_o          out  1    level: STATUS.DONE & CTRL.IRQ_EN
//  core_start_o   out  1    1-cycle start pulse to engine
//  core_op_o      out  2    2'b00 encrypt, 2'b01 decrypt
//  core_key_o     out  128  {KEY0,KEY1,KEY2,KEY3}, KEY0 = [127:96]
//  core_data_o    out  128  {DATA0..DATA3}, DATA0 = [127:96]
//  core_result_i  in   128  engine result, RESULT0 = [127:96]
//  core_valid_i   in   1    engine result valid (sticky until next start)
//  core_ready_i   in   1    engine idle
// BEHAVIOUR
//  Reset: all registers 0, CTRL.IRQ_EN=IRQ_EN_RST; all outputs 0; FSM IDLE.
//  Map: 0x00-0x0C KEY0-3 RW | 0x10-0x1C DATA0-3 RW | 0x20-0x2C RESULT0-3 RO | 0x30 CTRL
//   {IRQ_EN[2], OP[1], START[0] W1 self-clear, reads 0} | 0x34 STATUS {ERR[2] W1C, DONE[1] W1C,
//   BUSY[0] RO}. Unmapped reads return 0; unmapped and RO writes are ignored without error.
//  FSM states: IDLE -> LAUNCH -> ACCEPT -> BUSY -> IDLE.
//   IDLE: a CTRL write with START=1 latches OP, clears DONE, goes to LAUNCH.
//   LAUNCH: core_start_o=1 in the first cycle core_ready_i=1, then go to ACCEPT. Hold while not ready.
//   ACCEPT: wait for core_ready_i=0 (engine has left WAIT), then go to BUSY.
//   BUSY: when core_valid_i & core_ready_i, RESULT0-3 <= core_result_i, DONE<=1, go to IDLE.
//  BUSY bit = (state != IDLE). Latency from the START write to DONE = 1 + engine latency + 2 cycles.
//  core_key_o/core_data_o/core_op_o are driven straight from registers and held stable during an op.
//  While BUSY=1:
//   - KEY/DATA writes are dropped and set ERR=1.
//   - START=1 writes are dropped and set ERR=1.
//   - IRQ_EN/OP bits of a CTRL write still update IRQ_EN; OP is ignored.
//  Simultaneous events:
//   - DONE W1C in the same cycle as completion: DONE ends at 1 (set wins).
//   - ERR W1C in the same cycle as a new error: ERR ends at 1.
//   - A read in the same cycle as a register write returns the pre-write value.
//   - wr_i and rd_i asserted together are both serviced.
//  RESULT registers persist until the next completion. Reset mid-operation returns to IDLE and
//   drops any pending result.
// STRUCTURE
//  aes128_type_pkg gains: register offset localparams (AES_REG_KEY0..AES_REG_STATUS), CTRL/STATUS
//   bit index localparams, and enum bus_ctrl_state_t {BC_IDLE,BC_LAUNCH,BC_ACCEPT,BC_BUSY}.
//  No sub-module. The peripheral top instantiates aes128_bus_ctrl alongside aes128_fsm.
// TESTING
//  1 FIPS-197 encrypt: KEY=000102..0f, DATA=00112233445566778899aabbccddeeff, CTRL=0x1
//    -> single core_start_o pulse, DONE=1, RESULT=69c4e0d86a7b0430d8cdb78070b4c55a.
//  2 Decrypt: same key, DATA=69c4e0d8..., CTRL=0x3 -> core_op_o=01, RESULT=00112233...eeff.
//  3 During BUSY, write DATA0=0xdeadbeef and CTRL=0x1 -> DATA0 unchanged, ERR=1, exactly one start
//    pulse; writing STATUS=0x4 then clears ERR.
//  4 IRQ_EN=1 -> irq_o rises the cycle DONE sets; STATUS=0x2 write drops irq_o. A W1C coincident
//    with completion (model-forced core_valid_i) -> DONE stays 1.
//  5 Model holds core_ready_i=0 for 5 cycles after START -> FSM stays in LAUNCH, start pulse issued
//    on the first ready cycle only.
//  6 Assert rst_n_i mid-BUSY -> next cycle BUSY=0, DONE=0, RESULT=0, irq_o=0; a fresh op completes.

Source files
------------

// File: rtl/aes128_type_pkg.sv
// Shared types and register map for the AES-128 peripheral.
package aes128_type_pkg;

  localparam int unsigned AES_BUS_DW = 32;
  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_WORDS  = AES_BLK_W / AES_BUS_DW;

  // Byte offsets of the memory-mapped registers
  localparam logic [5:0] AES_REG_KEY0    = 6'h00;
  localparam logic [5:0] AES_REG_KEY1    = 6'h04;
  localparam logic [5:0] AES_REG_KEY2    = 6'h08;
  localparam logic [5:0] AES_REG_KEY3    = 6'h0C;
  localparam logic [5:0] AES_REG_DATA0   = 6'h10;
  localparam logic [5:0] AES_REG_DATA1   = 6'h14;
  localparam logic [5:0] AES_REG_DATA2   = 6'h18;
  localparam logic [5:0] AES_REG_DATA3   = 6'h1C;
  localparam logic [5:0] AES_REG_RESULT0 = 6'h20;
  localparam logic [5:0] AES_REG_RESULT1 = 6'h24;
  localparam logic [5:0] AES_REG_RESULT2 = 6'h28;
  localparam logic [5:0] AES_REG_RESULT3 = 6'h2C;
  localparam logic [5:0] AES_REG_CTRL    = 6'h30;
  localparam logic [5:0] AES_REG_STATUS  = 6'h34;

  // CTRL bit positions
  localparam int unsigned AES_CTRL_START  = 0;
  localparam int unsigned AES_CTRL_OP     = 1;
  localparam int unsigned AES_CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int unsigned AES_STAT_BUSY = 0;
  localparam int unsigned AES_STAT_DONE = 1;
  localparam int unsigned AES_STAT_ERR  = 2;

  // 128-bit block as four bus words; element 3 holds word 0 ([127:96])
  typedef logic [AES_WORDS-1:0][AES_BUS_DW-1:0] aes_block_t;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_LAUNCH,
    BC_ACCEPT,
    BC_BUSY
  } bus_ctrl_state_t;

endpackage

// File: rtl/aes128_bus_ctrl.sv
// Bus-side register file and launch/capture controller for the AES-128 engine.
module aes128_bus_ctrl
  import aes128_type_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter bit          IRQ_EN_RST = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [AES_BUS_DW-1:0] wdata_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  output logic [AES_BUS_DW-1:0] rdata_o,
  output logic                  rd_valid_o,
  output logic                  irq_o,
  output logic                  core_start_o,
  output logic [1:0]            core_op_o,
  output logic [AES_BLK_W-1:0]  core_key_o,
  output logic [AES_BLK_W-1:0]  core_data_o,
  input  logic [AES_BLK_W-1:0]  core_result_i,
  input  logic                  core_valid_i,
  input  logic                  core_ready_i
);

  localparam logic [1:0] GRP_KEY    = AES_REG_KEY0[5:4];
  localparam logic [1:0] GRP_DATA   = AES_REG_DATA0[5:4];
  localparam logic [1:0] GRP_RESULT = AES_REG_RESULT0[5:4];
  localparam logic [1:0] GRP_CSR    = AES_REG_CTRL[5:4];
  localparam logic [1:0] SEL_CTRL   = AES_REG_CTRL[3:2];
  localparam logic [1:0] SEL_STATUS = AES_REG_STATUS[3:2];

  bus_ctrl_state_t       state_q, state_d;
  aes_block_t            key_q, key_d;
  aes_block_t            data_q, data_d;
  aes_block_t            result_q, result_d;
  logic                  op_q, op_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;
  logic                  rd_valid_q;
  logic [AES_BUS_DW-1:0] rdata_q, rdata_d;

  logic       busy_c;
  logic [1:0] grp_c;
  logic [1:0] wsel_c;
  logic [1:0] widx_c;
  logic       unused_addr_c;

  // Address decode: word 0 of a block lives in the top element
  assign grp_c         = addr_i[5:4];
  assign wsel_c        = addr_i[3:2];
  assign widx_c        = ~wsel_c;
  assign busy_c        = (state_q != BC_IDLE);
  assign unused_addr_c = ^addr_i[1:0];

  assign rdata_o      = rdata_q;
  assign rd_valid_o   = rd_valid_q;
  assign irq_o        = irq_q;
  assign core_start_o = (state_q == BC_LAUNCH) && core_ready_i;
  assign core_op_o    = {1'b0, op_q};
  assign core_key_o   = key_q;
  assign core_data_o  = data_q;

  // Bus writes, launch FSM and completion capture; completion is applied last so its set wins
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    data_d   = data_q;
    result_d = result_q;
    op_d     = op_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;

    if (wr_i) begin
      case (grp_c)
        GRP_KEY: begin
          if (busy_c) err_d = 1'b1;
          else        key_d[widx_c] = wdata_i;
        end
        GRP_DATA: begin
          if (busy_c) err_d = 1'b1;
          else        data_d[widx_c] = wdata_i;
        end
        GRP_CSR: begin
          if (wsel_c == SEL_CTRL) begin
            irq_en_d = wdata_i[AES_CTRL_IRQ_EN];
            if (busy_c) begin
              if (wdata_i[AES_CTRL_START]) err_d = 1'b1;
            end else begin
              op_d = wdata_i[AES_CTRL_OP];
              if (wdata_i[AES_CTRL_START]) begin
                done_d  = 1'b0;
                state_d = BC_LAUNCH;
              end
            end
          end else if (wsel_c == SEL_STATUS) begin
            if (wdata_i[AES_STAT_DONE]) done_d = 1'b0;
            if (wdata_i[AES_STAT_ERR])  err_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      BC_LAUNCH: if (core_ready_i)  state_d = BC_ACCEPT;
      BC_ACCEPT: if (!core_ready_i) state_d = BC_BUSY;
      BC_BUSY: begin
        if (core_valid_i && core_ready_i) begin
          result_d = core_result_i;
          done_d   = 1'b1;
          state_d  = BC_IDLE;
        end
      end
      default: ;
    endcase

    irq_d = done_d & irq_en_d;
  end

  // Read mux samples current register values, so a same-cycle write is not visible
  always_comb begin
    rdata_d = rdata_q;
    if (rd_i) begin
      rdata_d = '0;
      case (grp_c)
        GRP_KEY:    rdata_d = key_q[widx_c];
        GRP_DATA:   rdata_d = data_q[widx_c];
        GRP_RESULT: rdata_d = result_q[widx_c];
        GRP_CSR: begin
          if (wsel_c == SEL_CTRL)        rdata_d = 32'({irq_en_q, op_q, 1'b0});
          else if (wsel_c == SEL_STATUS) rdata_d = 32'({err_q, done_q, busy_c});
        end
        default: ;
      endcase
    end
  end

  // State and register update
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= BC_IDLE;
      key_q      <= '0;
      data_q     <= '0;
      result_q   <= '0;
      op_q       <= 1'b0;
      irq_en_q   <= IRQ_EN_RST;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      data_q     <= data_d;
      result_q   <= result_d;
      op_q       <= op_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
      rd_valid_q <= rd_i;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_aes128_bus_ctrl.sv
// Directed bench for aes128_bus_ctrl with a behavioural engine model.
module tb_aes128_bus_ctrl;
  import aes128_type_pkg::*;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int           ENG_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic [31:0]  rdata;
  logic         rd_valid;
  logic         irq;
  logic         core_start;
  logic [1:0]   core_op;
  logic [127:0] core_key;
  logic [127:0] core_data;
  logic [127:0] core_result;
  logic         core_valid;
  logic         core_ready;

  // engine model controls
  logic         hold  = 1'b0;  // force ready low
  logic         stall = 1'b0;  // engine does not finish
  logic         frc   = 1'b0;  // force valid & ready high
  logic         eng_ready;
  logic         eng_valid;
  logic [127:0] eng_res;
  int           eng_cnt;
  int           start_cnt = 0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign core_result = eng_res;
  assign core_valid  = eng_valid | frc;
  assign core_ready  = (eng_ready & ~hold) | frc;

  aes128_bus_ctrl #(.ADDR_W(6), .IRQ_EN_RST(1'b0)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .wr_i         (wr),
    .rd_i         (rd),
    .rdata_o      (rdata),
    .rd_valid_o   (rd_valid),
    .irq_o        (irq),
    .core_start_o (core_start),
    .core_op_o    (core_op),
    .core_key_o   (core_key),
    .core_data_o  (core_data),
    .core_result_i(core_result),
    .core_valid_i (core_valid),
    .core_ready_i (core_ready)
  );

  function automatic logic [127:0] eng_model(input logic [1:0] op, input logic [127:0] k,
                                             input logic [127:0] d);
    if (op == 2'b00 && k == KEY && d == PT) return CT;
    if (op == 2'b01 && k == KEY && d == CT) return PT;
    return ~d;
  endfunction

  // Behavioural engine: accepts start when ready, finishes ENG_LAT cycles later
  always @(posedge clk) begin
    if (!rst_n) begin
      eng_ready <= 1'b1;
      eng_valid <= 1'b0;
      eng_res   <= '0;
      eng_cnt   <= 0;
    end else if (core_start && core_ready) begin
      eng_ready <= 1'b0;
      eng_valid <= 1'b0;
      eng_cnt   <= ENG_LAT;
      eng_res   <= eng_model(core_op, core_key, core_data);
    end else if (!eng_ready && !stall) begin
      if (eng_cnt <= 1) begin
        eng_ready <= 1'b1;
        eng_valid <= 1'b1;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] d);
    for (int i = 0; i < 4; i++) bus_wr(6'(AES_REG_KEY0 + 6'(4 * i)), k[127 - 32 * i -: 32]);
    for (int i = 0; i < 4; i++) bus_wr(6'(AES_REG_DATA0 + 6'(4 * i)), d[127 - 32 * i -: 32]);
  endtask

  task automatic read_result(output logic [127:0] r);
    logic [31:0] w;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      bus_rd(6'(AES_REG_RESULT0 + 6'(4 * i)), w);
      r[127 - 32 * i -: 32] = w;
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      bus_rd(AES_REG_STATUS, s);
      seen = s[AES_STAT_DONE];
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1));
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  w;
    logic [127:0] r;
    int           sc;
    bit           hit;

    // Reset
    wait_neg(3);
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    check("rst_start", 128'(core_start), 128'(0));
    check("rst_key", core_key, 128'(0));
    rst_n = 1'b1;
    bus_rd(AES_REG_STATUS, w);
    check("rst_status", 128'(w), 128'(0));
    check("rd_valid_pulse", 128'(rd_valid), 128'(1));
    bus_rd(AES_REG_CTRL, w);
    check("rst_ctrl", 128'(w), 128'(0));

    // 1: FIPS-197 encrypt
    load(KEY, PT);
    check("t1_core_key", core_key, KEY);
    check("t1_core_data", core_data, PT);
    sc = start_cnt;
    bus_wr(AES_REG_CTRL, 32'h1);
    wait_done("t1");
    check("t1_starts", 128'(start_cnt - sc), 128'(1));
    read_result(r);
    check("t1_result", r, CT);
    bus_rd(AES_REG_STATUS, w);
    check("t1_status", 128'(w), 128'(2));

    // Register access corner cases
    bus_rd(6'h38, w);
    check("unmapped_rd", 128'(w), 128'(0));
    bus_wr(AES_REG_RESULT0, 32'h0);
    bus_rd(AES_REG_RESULT0, w);
    check("result_ro", 128'(w), 128'(32'h69c4e0d8));
    @(negedge clk);
    addr = AES_REG_KEY0; wdata = 32'h1111_2222; wr = 1'b1; rd = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    check("wr_rd_same_old", 128'(rdata), 128'(32'h0001_0203));
    bus_rd(AES_REG_KEY0, w);
    check("wr_rd_same_new", 128'(w), 128'(32'h1111_2222));
    bus_wr(AES_REG_KEY0, 32'h0001_0203);

    // 2: decrypt
    load(KEY, CT);
    bus_wr(AES_REG_CTRL, 32'h3);
    check("t2_core_op", 128'(core_op), 128'(1));
    wait_done("t2");
    read_result(r);
    check("t2_result", r, PT);
    bus_rd(AES_REG_CTRL, w);
    check("t2_ctrl_rd", 128'(w), 128'(2));

    // 3: writes while busy
    stall = 1'b1;
    sc = start_cnt;
    bus_wr(AES_REG_CTRL, 32'h3);
    wait_neg(4);
    bus_wr(AES_REG_DATA0, 32'hdeadbeef);
    bus_wr(AES_REG_CTRL, 32'h1);
    bus_rd(AES_REG_DATA0, w);
    check("t3_data0_kept", 128'(w), 128'(32'h69c4e0d8));
    bus_rd(AES_REG_STATUS, w);
    check("t3_status_err", 128'(w), 128'(5));
    check("t3_core_op_held", 128'(core_op), 128'(1));
    stall = 1'b0;
    wait_done("t3");
    check("t3_starts", 128'(start_cnt - sc), 128'(1));
    read_result(r);
    check("t3_result", r, PT);
    bus_wr(AES_REG_STATUS, 32'h4);
    bus_rd(AES_REG_STATUS, w);
    check("t3_err_clr", 128'(w), 128'(2));

    // 4: interrupt and DONE set/clear collision
    bus_wr(AES_REG_STATUS, 32'h2);
    bus_wr(AES_REG_CTRL, 32'h4);
    check("t4_irq_idle", 128'(irq), 128'(0));
    load(KEY, PT);
    bus_wr(AES_REG_CTRL, 32'h5);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = !core_ready;
    end
    check("t4_eng_busy", 128'(hit), 128'(1));
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = core_valid && core_ready;
    end
    check("t4_eng_done", 128'(hit), 128'(1));
    check("t4_irq_before", 128'(irq), 128'(0));
    @(negedge clk);
    check("t4_irq_rise", 128'(irq), 128'(1));
    bus_rd(AES_REG_STATUS, w);
    check("t4_status", 128'(w), 128'(2));
    bus_wr(AES_REG_STATUS, 32'h2);
    check("t4_irq_clr", 128'(irq), 128'(0));
    stall = 1'b1;
    bus_wr(AES_REG_CTRL, 32'h5);
    wait_neg(6);
    bus_rd(AES_REG_STATUS, w);
    check("t4_busy", 128'(w), 128'(1));
    @(negedge clk);
    addr = AES_REG_STATUS; wdata = 32'h2; wr = 1'b1; frc = 1'b1;
    @(negedge clk);
    wr = 1'b0; frc = 1'b0;
    bus_rd(AES_REG_STATUS, w);
    check("t4_done_set_wins", 128'(w), 128'(2));
    check("t4_irq_coincide", 128'(irq), 128'(1));
    stall = 1'b0;
    wait_neg(10);

    // 5: engine not ready at launch
    bus_wr(AES_REG_CTRL, 32'h0);
    sc = start_cnt;
    hold = 1'b1;
    bus_wr(AES_REG_CTRL, 32'h1);
    bus_rd(AES_REG_STATUS, w);
    check("t5_busy", 128'(w), 128'(1));
    wait_neg(2);
    check("t5_no_start", 128'(start_cnt - sc), 128'(0));
    check("t5_start_low", 128'(core_start), 128'(0));
    hold = 1'b0;
    #1;
    check("t5_start_on_ready", 128'(core_start), 128'(1));
    wait_done("t5");
    check("t5_starts", 128'(start_cnt - sc), 128'(1));
    read_result(r);
    check("t5_result", r, CT);

    // 6: reset in the middle of an operation
    stall = 1'b1;
    bus_wr(AES_REG_CTRL, 32'h5);
    wait_neg(6);
    stall = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_irq", 128'(irq), 128'(0));
    bus_rd(AES_REG_STATUS, w);
    check("t6_status", 128'(w), 128'(0));
    read_result(r);
    check("t6_result_zero", r, 128'(0));
    load(KEY, PT);
    bus_wr(AES_REG_CTRL, 32'h1);
    wait_done("t6");
    read_result(r);
    check("t6_result", r, CT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
